// File: rtl/xillybus_regbank_pkg.sv
// Shared defaults and helpers for the seekable Xillybus register bank.
package xillybus_regbank_pkg;

  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefNregs = 32;

  // Low bit index of register idx inside a flattened NREGS*width vector.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/xillybus_regbank_rdport.sv
// Read side of the register bank: seekable pointer, one-cycle seek bubble,
// empty/EOF derivation and the registered output word.
module xillybus_regbank_rdport
  import xillybus_regbank_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned NREGS  = DefNregs,
  parameter bit          WRAP   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    quiesce,
  input  logic                    rden,
  input  logic                    open,
  input  logic [ADDR_W-1:0]       raddr,
  input  logic                    raddr_update,
  input  logic [NREGS*DATA_W-1:0] regs,
  output logic [DATA_W-1:0]       data,
  output logic                    empty,
  output logic                    eof
);

  localparam int unsigned PW = ADDR_W + 1;
  localparam logic [PW-1:0] NregsP = PW'(NREGS);
  localparam logic [PW-1:0] LastIdx = PW'(NREGS - 1);

  logic [PW-1:0]     rptr_q, rnext;
  logic              bubble_q, past_end, fire;
  logic [DATA_W-1:0] data_q, rd_word;

  always_comb begin
    past_end = !WRAP && (rptr_q >= NregsP);
    empty    = bubble_q || past_end;
    eof      = past_end && !bubble_q;
    fire     = rden && open && !empty && !raddr_update && !quiesce;
    rd_word  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rptr_q == PW'(i)) rd_word = regs[slice_lo(i, DATA_W) +: DATA_W];
    end
    // Saturate rather than overflow so a run-off pointer never aliases back to 0.
    if (WRAP && rptr_q >= LastIdx) rnext = '0;
    else if (rptr_q == '1)         rnext = rptr_q;
    else                           rnext = rptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q   <= '0;
      bubble_q <= 1'b1;
      data_q   <= '0;
    end else begin
      bubble_q <= raddr_update;
      if (quiesce) begin
        rptr_q <= '0;
      end else if (raddr_update) begin
        rptr_q <= {1'b0, raddr};
      end else if (fire) begin
        rptr_q <= rnext;
        data_q <= rd_word;
      end
    end
  end

  assign data = data_q;

endmodule

// File: rtl/xillybus_regbank.sv
// Register bank behind a seekable Xillybus write/read stream pair, with
// per-register hardware write ports, read-only masking and drop accounting.
module xillybus_regbank
  import xillybus_regbank_pkg::*;
#(
  parameter int unsigned             ADDR_W    = DefAddrW,
  parameter int unsigned             DATA_W    = DefDataW,
  parameter int unsigned             NREGS     = DefNregs,
  parameter logic [NREGS-1:0]        RO_MASK   = '0,
  parameter logic [NREGS*DATA_W-1:0] RESET_VAL = '0,
  parameter bit                      WRAP      = 1'b0
) (
  input  logic                    bus_clk,
  input  logic                    trn_reset_n,
  input  logic                    quiesce,
  input  logic                    user_w_wren,
  input  logic [DATA_W-1:0]       user_w_data,
  output logic                    user_w_full,
  input  logic                    user_w_open,
  input  logic [ADDR_W-1:0]       user_waddr,
  input  logic                    user_waddr_update,
  input  logic                    user_r_rden,
  output logic [DATA_W-1:0]       user_r_data,
  output logic                    user_r_empty,
  output logic                    user_r_eof,
  input  logic                    user_r_open,
  input  logic [ADDR_W-1:0]       user_raddr,
  input  logic                    user_raddr_update,
  output logic [NREGS*DATA_W-1:0] reg_q,
  output logic [NREGS-1:0]        reg_wr_pulse,
  input  logic [NREGS-1:0]        hw_we,
  input  logic [NREGS*DATA_W-1:0] hw_d,
  output logic [7:0]              drop_cnt
);

  localparam int unsigned PW = ADDR_W + 1;
  localparam logic [PW-1:0] LastIdx = PW'(NREGS - 1);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [PW-1:0]     wptr_q, weff, wnext;
  logic [NREGS-1:0]  hit, pulse_q;
  logic              host_wr, drop, full_q;
  logic [7:0]        drop_q;

  always_comb begin
    // A seek coincident with a write redirects that write to the seek address.
    weff    = user_waddr_update ? {1'b0, user_waddr} : wptr_q;
    host_wr = user_w_wren && user_w_open && !quiesce;
    hit     = '0;
    for (int i = 0; i < NREGS; i++) begin
      hit[i] = host_wr && (weff == PW'(i)) && !RO_MASK[i];
    end
    drop = host_wr && (hit == '0);
    if (WRAP && weff >= LastIdx) wnext = '0;
    else if (weff == '1)         wnext = weff;
    else                         wnext = weff + PW'(1);
  end

  always_ff @(posedge bus_clk) begin
    if (!trn_reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VAL[slice_lo(i, DATA_W) +: DATA_W];
      end
      wptr_q  <= '0;
      pulse_q <= '0;
      drop_q  <= '0;
      full_q  <= 1'b1;
    end else begin
      // hit[] is never set on read-only registers, so hw_we always lands there.
      for (int i = 0; i < NREGS; i++) begin
        if (hit[i])        regs_q[i] <= user_w_data;
        else if (hw_we[i]) regs_q[i] <= hw_d[slice_lo(i, DATA_W) +: DATA_W];
      end
      if (quiesce)                wptr_q <= '0;
      else if (host_wr)           wptr_q <= wnext;
      else if (user_waddr_update) wptr_q <= {1'b0, user_waddr};
      pulse_q <= hit;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      full_q <= 1'b0;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_q[slice_lo(i, DATA_W) +: DATA_W] = regs_q[i];
    end
  end

  assign reg_wr_pulse = pulse_q;
  assign drop_cnt     = drop_q;
  assign user_w_full  = full_q;

  xillybus_regbank_rdport #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .WRAP   (WRAP)
  ) u_rdport (
    .clk          (bus_clk),
    .rst_n        (trn_reset_n),
    .quiesce      (quiesce),
    .rden         (user_r_rden),
    .open         (user_r_open),
    .raddr        (user_raddr),
    .raddr_update (user_raddr_update),
    .regs         (reg_q),
    .data         (user_r_data),
    .empty        (user_r_empty),
    .eof          (user_r_eof)
  );

endmodule

// File: tb/tb_xillybus_regbank.sv
// Directed bench for xillybus_regbank: a 32x32 bank with RO register 7 and a
// 4x8 wrapping bank share the clock and reset.
module tb_xillybus_regbank;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam logic [NR-1:0] RO = 32'h0000_0080;

  function automatic logic [NR*DW-1:0] mk_rv();
    logic [NR*DW-1:0] rv;
    for (int i = 0; i < NR; i++) rv[i*DW +: DW] = 32'hC0DE_0000 + i;
    return rv;
  endfunction

  localparam logic [NR*DW-1:0] RV = mk_rv();

  function automatic logic [DW-1:0] exp_rv(input int i);
    return 32'hC0DE_0000 + i;
  endfunction

  logic bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  logic trn_reset_n, quiesce, user_w_wren, user_w_open, user_waddr_update;
  logic user_r_rden, user_r_open, user_raddr_update;
  logic [DW-1:0] user_w_data, user_r_data;
  logic [AW-1:0] user_waddr, user_raddr;
  logic user_w_full, user_r_empty, user_r_eof;
  logic [NR*DW-1:0] reg_q, hw_d;
  logic [NR-1:0] reg_wr_pulse, hw_we;
  logic [7:0] drop_cnt;

  logic w_rden, w_raddr_update, w_r_empty, w_r_eof, w_w_full;
  logic [1:0] w_raddr;
  logic [7:0] w_r_data, w_drop;
  logic [31:0] w_reg_q;
  logic [3:0] w_pulse;

  int checks = 0;
  int errors = 0;

  xillybus_regbank #(
    .ADDR_W(AW), .DATA_W(DW), .NREGS(NR), .RO_MASK(RO), .RESET_VAL(RV), .WRAP(1'b0)
  ) dut (
    .bus_clk           (bus_clk),
    .trn_reset_n       (trn_reset_n),
    .quiesce           (quiesce),
    .user_w_wren       (user_w_wren),
    .user_w_data       (user_w_data),
    .user_w_full       (user_w_full),
    .user_w_open       (user_w_open),
    .user_waddr        (user_waddr),
    .user_waddr_update (user_waddr_update),
    .user_r_rden       (user_r_rden),
    .user_r_data       (user_r_data),
    .user_r_empty      (user_r_empty),
    .user_r_eof        (user_r_eof),
    .user_r_open       (user_r_open),
    .user_raddr        (user_raddr),
    .user_raddr_update (user_raddr_update),
    .reg_q             (reg_q),
    .reg_wr_pulse      (reg_wr_pulse),
    .hw_we             (hw_we),
    .hw_d              (hw_d),
    .drop_cnt          (drop_cnt)
  );

  xillybus_regbank #(
    .ADDR_W(2), .DATA_W(8), .NREGS(4), .RO_MASK(4'b0000), .RESET_VAL(32'h4433_2211),
    .WRAP(1'b1)
  ) dut_wrap (
    .bus_clk           (bus_clk),
    .trn_reset_n       (trn_reset_n),
    .quiesce           (1'b0),
    .user_w_wren       (1'b0),
    .user_w_data       (8'h00),
    .user_w_full       (w_w_full),
    .user_w_open       (1'b1),
    .user_waddr        (2'b00),
    .user_waddr_update (1'b0),
    .user_r_rden       (w_rden),
    .user_r_data       (w_r_data),
    .user_r_empty      (w_r_empty),
    .user_r_eof        (w_r_eof),
    .user_r_open       (1'b1),
    .user_raddr        (w_raddr),
    .user_raddr_update (w_raddr_update),
    .reg_q             (w_reg_q),
    .reg_wr_pulse      (w_pulse),
    .hw_we             (4'b0000),
    .hw_d              (32'h0),
    .drop_cnt          (w_drop)
  );

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic test_reset();
    trn_reset_n = 1'b0;
    tick();
    tick();
    checks++; if (user_r_data !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h want 0", user_r_data); end
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL reset_empty: got %b want 1", user_r_empty); end
    checks++; if (user_r_eof !== 1'b0) begin errors++;
      $display("FAIL reset_eof: got %b want 0", user_r_eof); end
    checks++; if (user_w_full !== 1'b1) begin errors++;
      $display("FAIL reset_full: got %b want 1", user_w_full); end
    checks++; if (reg_wr_pulse !== '0 || drop_cnt !== 8'd0) begin errors++;
      $display("FAIL reset_pulse_drop: got %h/%0d want 0/0", reg_wr_pulse, drop_cnt); end
    trn_reset_n = 1'b1;
    tick();
    checks++; if (user_w_full !== 1'b0) begin errors++;
      $display("FAIL full_after_reset: got %b want 0", user_w_full); end
  endtask

  task automatic test_reset_reads();
    user_raddr = 5'd0;
    user_raddr_update = 1'b1;
    tick();
    user_raddr_update = 1'b0;
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL seek0_bubble: got %b want 1", user_r_empty); end
    tick();
    user_r_rden = 1'b1;
    for (int i = 0; i < NR; i++) begin
      tick();
      checks++; if (user_r_data !== exp_rv(i)) begin errors++;
        $display("FAIL reset_read[%0d]: got %h want %h", i, user_r_data, exp_rv(i)); end
    end
    user_r_rden = 1'b0;
    checks++; if (user_r_empty !== 1'b1 || user_r_eof !== 1'b1) begin errors++;
      $display("FAIL end_of_space: got empty=%b eof=%b want 1/1", user_r_empty, user_r_eof); end
  endtask

  task automatic test_write_readback();
    user_waddr = 5'd3;
    user_waddr_update = 1'b1;
    user_w_wren = 1'b1;
    user_w_data = 32'hA5A5_0001;
    tick();
    user_waddr_update = 1'b0;
    checks++; if (reg_wr_pulse !== 32'h8 || reg_q[3*DW +: DW] !== 32'hA5A5_0001) begin errors++;
      $display("FAIL write_reg3: got pulse=%h reg=%h want 8/a5a50001",
               reg_wr_pulse, reg_q[3*DW +: DW]); end
    user_w_data = 32'hA5A5_0002;
    tick();
    user_w_wren = 1'b0;
    checks++; if (reg_wr_pulse !== 32'h10 || reg_q[4*DW +: DW] !== 32'hA5A5_0002) begin errors++;
      $display("FAIL write_reg4: got pulse=%h reg=%h want 10/a5a50002",
               reg_wr_pulse, reg_q[4*DW +: DW]); end
    tick();
    checks++; if (reg_wr_pulse !== '0) begin errors++;
      $display("FAIL pulse_one_cycle: got %h want 0", reg_wr_pulse); end
    user_raddr = 5'd3;
    user_raddr_update = 1'b1;
    tick();
    user_raddr_update = 1'b0;
    tick();
    user_r_rden = 1'b1;
    tick();
    checks++; if (user_r_data !== 32'hA5A5_0001) begin errors++;
      $display("FAIL readback3: got %h want a5a50001", user_r_data); end
    tick();
    user_r_rden = 1'b0;
    checks++; if (user_r_data !== 32'hA5A5_0002) begin errors++;
      $display("FAIL readback4: got %h want a5a50002", user_r_data); end
  endtask

  task automatic test_ro_drop();
    user_waddr = 5'd7;
    user_waddr_update = 1'b1;
    user_w_wren = 1'b1;
    user_w_data = 32'h0000_DEAD;
    tick();
    user_waddr_update = 1'b0;
    user_w_wren = 1'b0;
    checks++; if (reg_q[7*DW +: DW] !== exp_rv(7) || drop_cnt !== 8'd1 || reg_wr_pulse !== '0)
      begin errors++;
      $display("FAIL ro_drop: got reg=%h drop=%0d pulse=%h want %h/1/0",
               reg_q[7*DW +: DW], drop_cnt, reg_wr_pulse, exp_rv(7)); end
    hw_we = 32'h80;
    hw_d[7*DW +: DW] = 32'h0000_1234;
    tick();
    hw_we = '0;
    checks++; if (reg_q[7*DW +: DW] !== 32'h0000_1234) begin errors++;
      $display("FAIL hw_write_ro: got %h want 00001234", reg_q[7*DW +: DW]); end
    user_waddr = 5'd31;
    user_waddr_update = 1'b1;
    user_w_wren = 1'b1;
    user_w_data = 32'hBEEF_0031;
    tick();
    user_waddr_update = 1'b0;
    user_w_data = 32'hBEEF_0032;
    tick();
    user_w_wren = 1'b0;
    checks++; if (reg_q[31*DW +: DW] !== 32'hBEEF_0031 || drop_cnt !== 8'd2 || reg_wr_pulse !== '0)
      begin errors++;
      $display("FAIL out_of_range_drop: got reg=%h drop=%0d pulse=%h want beef0031/2/0",
               reg_q[31*DW +: DW], drop_cnt, reg_wr_pulse); end
  endtask

  task automatic test_collision();
    user_waddr = 5'd2;
    user_waddr_update = 1'b1;
    user_w_wren = 1'b1;
    user_w_data = 32'h22;
    hw_we = 32'h4;
    hw_d[2*DW +: DW] = 32'h11;
    tick();
    user_waddr_update = 1'b0;
    user_w_wren = 1'b0;
    hw_we = '0;
    checks++; if (reg_q[2*DW +: DW] !== 32'h22 || reg_wr_pulse !== 32'h4) begin errors++;
      $display("FAIL collision: got reg=%h pulse=%h want 22/4", reg_q[2*DW +: DW], reg_wr_pulse); end
  endtask

  task automatic test_quiesce();
    quiesce = 1'b1;
    user_waddr = 5'd5;
    user_waddr_update = 1'b1;
    user_w_wren = 1'b1;
    user_w_data = 32'hFFFF_FFFF;
    tick();
    user_waddr_update = 1'b0;
    user_w_wren = 1'b0;
    quiesce = 1'b0;
    checks++; if (reg_q[5*DW +: DW] !== exp_rv(5) || drop_cnt !== 8'd2 || user_w_full !== 1'b0)
      begin errors++;
      $display("FAIL quiesce_write: got reg=%h drop=%0d full=%b want %h/2/0",
               reg_q[5*DW +: DW], drop_cnt, user_w_full, exp_rv(5)); end
  endtask

  task automatic test_wrap();
    w_raddr = 2'd3;
    w_raddr_update = 1'b1;
    tick();
    w_raddr_update = 1'b0;
    tick();
    w_rden = 1'b1;
    tick();
    checks++; if (w_r_data !== 8'h44 || w_r_eof !== 1'b0) begin errors++;
      $display("FAIL wrap_read3: got %h eof=%b want 44/0", w_r_data, w_r_eof); end
    tick();
    checks++; if (w_r_data !== 8'h11 || w_r_eof !== 1'b0) begin errors++;
      $display("FAIL wrap_read0: got %h eof=%b want 11/0", w_r_data, w_r_eof); end
    tick();
    w_rden = 1'b0;
    checks++; if (w_r_data !== 8'h22 || w_r_eof !== 1'b0 || w_r_empty !== 1'b0) begin errors++;
      $display("FAIL wrap_read1: got %h eof=%b empty=%b want 22/0/0", w_r_data, w_r_eof, w_r_empty); end
  endtask

  task automatic test_seek_mid_read_reset();
    user_raddr = 5'd0;
    user_raddr_update = 1'b1;
    tick();
    user_raddr_update = 1'b0;
    tick();
    user_r_rden = 1'b1;
    tick();
    tick();
    checks++; if (user_r_data !== exp_rv(1)) begin errors++;
      $display("FAIL burst_read1: got %h want %h", user_r_data, exp_rv(1)); end
    user_raddr = 5'd10;
    user_raddr_update = 1'b1;
    tick();
    user_raddr_update = 1'b0;
    checks++; if (user_r_empty !== 1'b1 || user_r_data !== exp_rv(1)) begin errors++;
      $display("FAIL seek_bubble: got empty=%b data=%h want 1/%h", user_r_empty, user_r_data,
               exp_rv(1)); end
    tick();
    checks++; if (user_r_empty !== 1'b0 || user_r_data !== exp_rv(1)) begin errors++;
      $display("FAIL bubble_len: got empty=%b data=%h want 0/%h", user_r_empty, user_r_data,
               exp_rv(1)); end
    tick();
    checks++; if (user_r_data !== exp_rv(10)) begin errors++;
      $display("FAIL seek_read10: got %h want %h", user_r_data, exp_rv(10)); end
    trn_reset_n = 1'b0;
    tick();
    checks++; if (user_r_data !== 32'h0 || user_r_empty !== 1'b1 || user_r_eof !== 1'b0 ||
                  user_w_full !== 1'b1 || drop_cnt !== 8'd0 || reg_wr_pulse !== '0) begin errors++;
      $display("FAIL midburst_reset: got data=%h empty=%b eof=%b full=%b drop=%0d pulse=%h",
               user_r_data, user_r_empty, user_r_eof, user_w_full, drop_cnt, reg_wr_pulse); end
    checks++; if (reg_q[2*DW +: DW] !== exp_rv(2) || reg_q[7*DW +: DW] !== exp_rv(7)) begin
      errors++;
      $display("FAIL reset_regs: got r2=%h r7=%h want %h/%h", reg_q[2*DW +: DW],
               reg_q[7*DW +: DW], exp_rv(2), exp_rv(7)); end
    user_r_rden = 1'b0;
    trn_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    trn_reset_n = 1'b0;
    quiesce = 1'b0;
    user_w_wren = 1'b0;
    user_w_data = '0;
    user_w_open = 1'b1;
    user_waddr = '0;
    user_waddr_update = 1'b0;
    user_r_rden = 1'b0;
    user_r_open = 1'b1;
    user_raddr = '0;
    user_raddr_update = 1'b0;
    hw_we = '0;
    hw_d = '0;
    w_rden = 1'b0;
    w_raddr = '0;
    w_raddr_update = 1'b0;
    test_reset();
    test_reset_reads();
    test_write_readback();
    test_ro_drop();
    test_collision();
    test_quiesce();
    test_wrap();
    test_seek_mid_read_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
